// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor: one decimal digit per clock, LSD first,
// one shared digit adder; negative differences leave as sign + magnitude via a FIX pass.
module bcd_addsub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   result,
  output logic                  carry,
  output logic                  neg,
  output logic                  err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, ADD, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic             c_q;
  logic [W-1:0]     a_q, b_q;
  logic             mode_q, bad_q;
  logic [W-1:0]     result_q;
  logic             carry_q, neg_q, err_q;

  logic [3:0]       a_dig, b_dig, r_dig, op_x, op_y, sum_dig;
  logic             sum_c, last;

  // Decimal correction: a 5-bit digit sum above 9 wraps by adding 6 and raises the carry.
  function automatic logic [4:0] dec_adj(input logic [4:0] z);
    logic [4:0] t;
    t = z + 5'd6;
    if (z > 5'd9) dec_adj = {1'b1, t[3:0]};
    else          dec_adj = {1'b0, z[3:0]};
  endfunction

  function automatic logic [3:0] nines(input logic [3:0] d);
    nines = 4'd9 - d;
  endfunction

  function automatic logic has_bad(input logic [W-1:0] v);
    has_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) has_bad = 1'b1;
  endfunction

  function automatic logic [3:0] pick(input logic [W-1:0] v, input logic [IDX_W-1:0] k);
    pick = 4'd0;
    for (int i = 0; i < DIGITS; i++)
      if (k == IDX_W'(i)) pick = v[4*i +: 4];
  endfunction

  // Shared digit adder: ADD pass uses a_i + b'_i, FIX pass uses (9 - r_i) + 0.
  always_comb begin
    a_dig = pick(a_q, idx_q);
    b_dig = pick(b_q, idx_q);
    r_dig = pick(result_q, idx_q);
    if (state_q == FIX) begin
      op_x = nines(r_dig);
      op_y = 4'd0;
    end else begin
      op_x = a_dig;
      op_y = mode_q ? nines(b_dig) : b_dig;
    end
    {sum_c, sum_dig} = dec_adj({1'b0, op_x} + {1'b0, op_y} + {4'd0, c_q});
    last = (idx_q == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ADD;
      end
      ADD: begin
        if (bad_q)     state_d = DONE;
        else if (last) state_d = (mode_q && !sum_c) ? FIX : DONE;
      end
      FIX: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture at accept; only read while busy, so no reset needed.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      a_q    <= a;
      b_q    <= b;
      mode_q <= mode;
      bad_q  <= has_bad(a) | has_bad(b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      c_q      <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            idx_q    <= '0;
            c_q      <= mode;
            result_q <= '0;
            carry_q  <= 1'b0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
          end
        end
        ADD: begin
          if (bad_q) begin
            err_q <= 1'b1;
          end else begin
            for (int i = 0; i < DIGITS; i++)
              if (idx_q == IDX_W'(i)) result_q[4*i +: 4] <= sum_dig;
            c_q <= sum_c;
            if (last) begin
              idx_q <= '0;
              if (!mode_q) begin
                carry_q <= sum_c;
              end else if (!sum_c) begin
                neg_q <= 1'b1;
                c_q   <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        FIX: begin
          for (int i = 0; i < DIGITS; i++)
            if (idx_q == IDX_W'(i)) result_q[4*i +: 4] <= sum_dig;
          c_q <= sum_c;
          if (last) idx_q <= '0;
          else      idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign carry  = carry_q;
  assign neg    = neg_q;
  assign err    = err_q;

endmodule
